// File: rtl/div_unit_param.sv
// Multi-cycle restoring divider (DIV/DIVU) for the MIPS datapath.
// Quotient goes to low (LO), remainder to high (HI); one quotient bit per CALC cycle.
module div_unit_param #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] high,
    output logic [WIDTH-1:0] low,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] dividend_reg;   // shifts dividend out at the top, quotient bits in at the bottom
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH:0]   rem_reg;
    logic [CW-1:0]    count_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             q_bit;

    always_comb begin
        a_neg     = is_signed & A[WIDTH-1];
        b_neg     = is_signed & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
        rem_shift = (rem_reg << 1) | {{WIDTH{1'b0}}, dividend_reg[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, divisor_reg};
        q_bit     = (rem_shift >= {1'b0, divisor_reg});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            count_reg    <= '0;
            q_neg_reg    <= 1'b0;
            r_neg_reg    <= 1'b0;
            high         <= '0;
            low          <= '0;
            div0         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (B == '0) begin
                            high      <= A;
                            low       <= '1;
                            div0      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            dividend_reg <= a_mag;
                            divisor_reg  <= b_mag;
                            rem_reg      <= '0;
                            count_reg    <= '0;
                            q_neg_reg    <= a_neg ^ b_neg;
                            r_neg_reg    <= a_neg;
                            state_reg    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg      <= q_bit ? rem_sub : rem_shift;
                    dividend_reg <= {dividend_reg[WIDTH-2:0], q_bit};
                    count_reg    <= count_reg + CW'(1);
                    if (count_reg == LAST_STEP)
                        state_reg <= FIX;
                end
                FIX: begin
                    // Most-negative / -1 wraps back to most-negative here.
                    low       <= q_neg_reg ? -dividend_reg : dividend_reg;
                    high      <= r_neg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
                    div0      <= 1'b0;
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg == CALC) || (state_reg == FIX);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_div_unit_param.sv
// Directed bench for div_unit_param: a 32-bit and an 8-bit instance side by side.
module tb_div_unit_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start32 = 1'b0, s32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [31:0] high32, low32;
    logic        busy32, done32, div0_32;

    logic        start8 = 1'b0, s8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [7:0]  high8, low8;
    logic        busy8, done8, div0_8;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    div_unit_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .is_signed(s32),
        .A(a32), .B(b32), .high(high32), .low(low32),
        .busy(busy32), .done(done32), .div0(div0_32)
    );

    div_unit_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(s8),
        .A(a8), .B(b8), .high(high8), .low(low8),
        .busy(busy8), .done(done8), .div0(div0_8)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Starts one operation, follows it to done (bounded), then checks results and timing.
    // poke > 0 fires a competing start with other operands after that many edges.
    task automatic run_op(input string tag, input bit w8,
                          input logic [63:0] a, input logic [63:0] b, input bit s,
                          input logic [63:0] exp_low, input logic [63:0] exp_high,
                          input bit exp_div0, input int exp_lat, input int exp_busy,
                          input int poke);
        int n = 0;
        int busy_cnt = 0;
        bit seen = 0;
        logic [63:0] obs_low, obs_high;
        logic obs_div0, obs_done;
        @(negedge clk);
        if (w8) begin a8 = a[7:0]; b8 = b[7:0]; s8 = s; start8 = 1'b1; end
        else begin a32 = a[31:0]; b32 = b[31:0]; s32 = s; start32 = 1'b1; end
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            start8 = 1'b0;
            start32 = 1'b0;
            n++;
            // Scramble operand inputs after the start edge; the result must not care.
            if (w8) begin a8 = ~a[7:0]; b8 = 8'h05; s8 = ~s; end
            else begin a32 = ~a[31:0]; b32 = 32'h5; s32 = ~s; end
            if (n == poke) begin
                a32 = 32'd100; b32 = 32'd7; s32 = 1'b1; start32 = 1'b1;
            end
            if (w8 ? busy8 : busy32) busy_cnt++;
            if (w8 ? done8 : done32) seen = 1;
        end
        obs_low  = w8 ? {56'b0, low8}  : {32'b0, low32};
        obs_high = w8 ? {56'b0, high8} : {32'b0, high32};
        obs_div0 = w8 ? div0_8 : div0_32;
        check({tag, "_done_seen"}, {63'b0, seen}, 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, "_low"}, obs_low, exp_low);
        check({tag, "_high"}, obs_high, exp_high);
        check({tag, "_div0"}, {63'b0, obs_div0}, {63'b0, exp_div0});
        @(posedge clk);
        #1;
        obs_done = w8 ? done8 : done32;
        check({tag, "_done_pulse"}, {63'b0, obs_done}, 64'd0);
        $display("[TB] %s: edges=%0d busy=%0d low=%0h high=%0h div0=%0b",
                 tag, n, busy_cnt, obs_low, obs_high, obs_div0);
    endtask

    initial begin
        bit seen_done;

        repeat (3) @(posedge clk);
        #1;
        check("reset_low32", {32'b0, low32}, 64'd0);
        check("reset_high32", {32'b0, high32}, 64'd0);
        check("reset_flags32", {61'b0, busy32, done32, div0_32}, 64'd0);
        check("reset_flags8", {61'b0, busy8, done8, div0_8}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("u_7_2",      0, 64'd7,          64'd2,          0, 64'd3,          64'd1,          0, 34, 33, 0);
        run_op("s_m7_2",     0, 64'hFFFFFFF9,   64'd2,          1, 64'hFFFFFFFD,   64'hFFFFFFFF,   0, 34, 33, 0);
        run_op("s_7_m2",     0, 64'd7,          64'hFFFFFFFE,   1, 64'hFFFFFFFD,   64'd1,          0, 34, 33, 0);
        run_op("s_m7_m2",    0, 64'hFFFFFFF9,   64'hFFFFFFFE,   1, 64'd3,          64'hFFFFFFFF,   0, 34, 33, 0);
        run_op("u_big",      0, 64'hFFFFFFFF,   64'h80000000,   0, 64'd1,          64'h7FFFFFFF,   0, 34, 33, 0);
        run_op("s_big",      0, 64'hFFFFFFFF,   64'h80000000,   1, 64'd0,          64'hFFFFFFFF,   0, 34, 33, 0);
        run_op("div_zero",   0, 64'h1234,       64'd0,          0, 64'hFFFFFFFF,   64'h1234,       1, 1,  0,  0);
        run_op("s_overflow", 0, 64'h80000000,   64'hFFFFFFFF,   1, 64'h80000000,   64'd0,          0, 34, 33, 0);
        run_op("s_100_7",    0, 64'd100,        64'd7,          1, 64'd14,         64'd2,          0, 34, 33, 0);
        run_op("busy_start", 0, 64'd7,          64'd2,          0, 64'd3,          64'd1,          0, 34, 33, 5);
        run_op("w8_signed",  1, 64'h81,         64'h03,         1, 64'hD6,         64'hFF,         0, 10, 9,  0);
        run_op("w8_unsigned",1, 64'h81,         64'h03,         0, 64'h2B,         64'h00,         0, 10, 9,  0);
        run_op("w8_zero",    1, 64'h5A,         64'h00,         1, 64'hFF,         64'h5A,         1, 1,  0,  0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        a32 = 32'd50; b32 = 32'd3; s32 = 1'b0; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", {63'b0, busy32}, 64'd0);
        check("midrst_low", {32'b0, low32}, 64'd0);
        check("midrst_high", {32'b0, high32}, 64'd0);
        check("midrst_div0", {63'b0, div0_32}, 64'd0);
        seen_done = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done32) seen_done = 1;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done32 || busy32) seen_done = 1;
        end
        check("midrst_no_done", {63'b0, seen_done}, 64'd0);
        $display("[TB] mid_reset: outputs cleared, operation abandoned");

        run_op("after_rst",  0, 64'd50,         64'd3,          0, 64'd16,         64'd2,          0, 34, 33, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
